// File: rtl/clkdiv_pkg.sv
// Shared constants, ch_sel width helper and per-channel state record for the multi-channel divider.
// Counter fields are held at a fixed maximum width; channels zero-extend into them (CNT_W <= 32).
package clkdiv_pkg;

  localparam int MAX_CH    = 16;
  localparam int DEF_HALF  = 5000000;
  localparam int CNT_W_MAX = 32;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [CNT_W_MAX-1:0] cnt;
    logic [CNT_W_MAX-1:0] act_half;
    logic [CNT_W_MAX-1:0] pend_half;
    logic                 pend_valid;
    logic                 q;
    logic                 lock;
  } ch_state_t;

endpackage

// File: rtl/clkdiv_multi_if.sv
// Shared half-period load port: strobe, channel select, value, and registered rejection pulse.
// Load is never stalled; a bad request is flagged on load_err one cycle later.
interface clkdiv_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 23
);
  localparam int SEL_W = clkdiv_pkg::sel_width(NUM_CH);

  logic             load;
  logic [SEL_W-1:0] ch_sel;
  logic [CNT_W-1:0] div_val;
  logic             load_err;

  modport master (output load, ch_sel, div_val, input load_err);
  modport slave  (input load, ch_sel, div_val, output load_err);

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow half-period, toggle and lock; tick registered with clk_out edge.
// No backpressure: a write while running is shadowed and applied at the next terminal count.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W        = 23,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick,
  output logic             locked,
  output logic             upd_pending
);

  ch_state_t            st_q, st_d;
  logic                 tick_q, tick_d;
  logic                 tc;
  logic [CNT_W_MAX-1:0] wr_ext;

  assign wr_ext = CNT_W_MAX'(wr_val);
  assign tc     = (st_q.cnt == st_q.act_half - CNT_W_MAX'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q.cnt        <= '0;
      st_q.act_half   <= CNT_W_MAX'(DEFAULT_HALF);
      st_q.pend_half  <= '0;
      st_q.pend_valid <= 1'b0;
      st_q.q          <= 1'b0;
      st_q.lock       <= 1'b0;
      tick_q          <= 1'b0;
    end else begin
      st_q   <= st_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    tick_d = 1'b0;
    if (en) begin
      if (tc) begin
        st_d.q   = ~st_q.q;
        st_d.cnt = '0;
        tick_d   = 1'b1;
        if (st_q.pend_valid) begin
          st_d.act_half   = st_q.pend_half;
          st_d.pend_valid = 1'b0;
          st_d.lock       = 1'b0;
        end else begin
          st_d.lock = 1'b1;
        end
      end else begin
        st_d.cnt = st_q.cnt + CNT_W_MAX'(1);
      end
      // A write coinciding with terminal count lands after the old pending value is consumed.
      if (wr) begin
        st_d.pend_half  = wr_ext;
        st_d.pend_valid = 1'b1;
      end
    end else begin
      st_d.cnt  = '0;
      st_d.lock = 1'b0;
      if (wr) begin
        st_d.act_half   = wr_ext;
        st_d.pend_valid = 1'b0;
      end
    end
  end

  assign clk_out     = st_q.q;
  assign tick        = tick_q;
  assign locked      = st_q.lock;
  assign upd_pending = st_q.pend_valid;

endmodule

// File: rtl/clkdiv_multi.sv
// NUM_CH independent programmable dividers sharing one load port; outputs are registered, 0 latency.
// Loads are never stalled: valid ones write a channel, bad ones pulse load_err the next cycle.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 23,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  clkdiv_multi_if.slave     lp,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] locked,
  output logic [NUM_CH-1:0] upd_pending
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] wr;
  logic              load_ok;
  logic              load_err_q;

  // Widened compare so a non-power-of-two channel count rejects the unused selects.
  assign load_ok = (32'(lp.ch_sel) < NUM_CH) && (lp.div_val != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= lp.load && !load_ok;
    end
  end

  assign lp.load_err = load_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = lp.load && load_ok && (lp.ch_sel == SEL_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (en[i]),
      .wr         (wr[i]),
      .wr_val     (lp.div_val),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .locked     (locked[i]),
      .upd_pending(upd_pending[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: expected tick/load_err events are queued by the stimulus
// and consumed by an independent negedge monitor.
module tb_clkdiv_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int HALF   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clk_out, tick, locked, upd_pending;

  clkdiv_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) lp ();

  clkdiv_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(HALF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .lp         (lp),
    .clk_out    (clk_out),
    .tick       (tick),
    .locked     (locked),
    .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic q;
    logic lk;
    logic up;
  } ev_t;

  ev_t expq [NUM_CH][$];
  int  lerr_q[$];
  int  checks = 0;
  int  errors = 0;

  function void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function void push(int ch, int c, logic q, logic lk, logic up);
    ev_t e;
    e.cyc = c;
    e.q   = q;
    e.lk  = lk;
    e.up  = up;
    expq[ch].push_back(e);
  endfunction

  // Monitor: every tick or load_err pulse must match the next queued expectation.
  always @(negedge clk) begin
    ev_t e;
    int  lc;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tick[i] === 1'b1) begin
        if (expq[i].size() == 0) begin
          chk($sformatf("unexpected_tick_ch%0d", i), int'(tick[i]), 0);
        end else begin
          e = expq[i].pop_front();
          chk($sformatf("tick_cyc_ch%0d", i), cyc, e.cyc);
          chk($sformatf("clk_out_ch%0d", i), int'(clk_out[i]), int'(e.q));
          chk($sformatf("locked_ch%0d", i), int'(locked[i]), int'(e.lk));
          chk($sformatf("upd_pending_ch%0d", i), int'(upd_pending[i]), int'(e.up));
        end
      end
    end
    if (lp.load_err === 1'b1) begin
      if (lerr_q.size() == 0) begin
        chk("unexpected_load_err", int'(lp.load_err), 0);
      end else begin
        lc = lerr_q.pop_front();
        chk("load_err_cyc", cyc, lc);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_load(input int ch, input int v);
    lp.load    = 1'b1;
    lp.ch_sel  = 2'(ch);
    lp.div_val = 8'(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset      = 1'b1;
    en         = '0;
    lp.load    = 1'b0;
    lp.ch_sel  = '0;
    lp.div_val = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_upd_pending", int'(upd_pending), 0);
    chk("rst_load_err", int'(lp.load_err), 0);

    // Channel 0 alone at the default half-period of 5.
    reset = 1'b1;
    en    = 4'b0001;
    b     = cyc;
    push(0, b + 5, 1, 1, 0);
    push(0, b + 10, 0, 1, 0);
    push(0, b + 15, 1, 1, 0);

    // Disable at cnt=2, then re-enable: a full half-period before the next toggle.
    wait_until(b + 17);
    en = 4'b0000;
    wait_until(b + 18);
    chk("dis_locked0", int'(locked[0]), 0);
    chk("dis_clk_out0", int'(clk_out[0]), 1);
    wait_until(b + 24);
    en = 4'b0001;
    b  = cyc;
    push(0, b + 5, 0, 1, 0);
    push(0, b + 10, 1, 1, 0);
    push(0, b + 15, 0, 0, 0);
    push(0, b + 18, 1, 1, 0);
    push(0, b + 21, 0, 1, 0);

    // Reload to 3 while running at cnt=2.
    wait_until(b + 12);
    do_load(0, 3);
    wait_until(b + 13);
    lp.load = 1'b0;
    chk("pend_upd_pending0", int'(upd_pending[0]), 1);
    chk("pend_locked0", int'(locked[0]), 1);

    // Rejected zero load on ch1, direct load of 7 into idle ch2.
    wait_until(b + 21);
    b  = cyc;
    en = 4'b0000;
    do_load(1, 0);
    lerr_q.push_back(b + 1);
    wait_until(b + 1);
    do_load(2, 7);
    wait_until(b + 2);
    lp.load = 1'b0;
    en      = 4'b0100;
    push(2, b + 9, 1, 1, 0);
    push(2, b + 16, 0, 1, 0);
    push(2, b + 23, 1, 1, 0);
    wait_until(b + 3);
    chk("direct_no_pending", int'(upd_pending), 0);

    // All channels running, one pending update, then asynchronous reset mid-cycle.
    wait_until(b + 23);
    b  = cyc;
    en = 4'b1111;
    push(0, b + 3, 1, 1, 0);
    push(0, b + 6, 0, 1, 0);
    push(1, b + 5, 1, 1, 0);
    push(3, b + 5, 1, 1, 0);
    push(2, b + 7, 0, 1, 0);
    wait_until(b + 5);
    do_load(3, 9);
    wait_until(b + 6);
    lp.load = 1'b0;
    chk("pre_rst_upd_pending", int'(upd_pending), 4'b1000);
    wait_until(b + 7);
    #2 reset = 1'b0;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_upd_pending", int'(upd_pending), 0);
    wait_until(b + 9);
    reset = 1'b1;
    b     = cyc;
    for (int i = 0; i < NUM_CH; i++) begin
      push(i, b + 5, 1, 1, 0);
      push(i, b + 10, 0, 1, 0);
    end

    // Load 4 exactly on the terminal count that applies pending 3.
    wait_until(b + 10);
    en = 4'b0001;
    push(0, b + 15, 1, 0, 1);
    push(0, b + 18, 0, 0, 0);
    push(0, b + 22, 1, 1, 0);
    push(0, b + 26, 0, 1, 0);
    wait_until(b + 11);
    do_load(0, 3);
    wait_until(b + 12);
    lp.load = 1'b0;
    wait_until(b + 14);
    do_load(0, 4);
    wait_until(b + 15);
    lp.load = 1'b0;

    // Half-period 1 on ch1: toggles and ticks every cycle.
    wait_until(b + 26);
    b  = cyc;
    en = 4'b0000;
    do_load(1, 1);
    wait_until(b + 1);
    lp.load = 1'b0;
    en      = 4'b0010;
    push(1, b + 2, 1, 1, 0);
    push(1, b + 3, 0, 1, 0);
    push(1, b + 4, 1, 1, 0);
    push(1, b + 5, 0, 1, 0);
    wait_until(b + 5);
    en = 4'b0000;
    wait_until(b + 10);

    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("missing_ticks_ch%0d", i), expq[i].size(), 0);
    chk("missing_load_err", lerr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Parametrised multi-channel programmable clock divider, the successor to our single-channel fixed divider. Each of NUM_CH channels produces a square-wave output, a one-cycle tick and a locked flag. Each channel's half-period is reprogrammed at run time through a shared load port. New values are applied glitch-free at the next terminal count. The block sits beside the top-level clock source and feeds slow strobes to display scan, debounce and LED blink logic.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 23, width of counter and half-period registers
DEFAULT_HALF, 5000000, half-period (in clk cycles) loaded into every channel at reset; must be nonzero and < 2**CNT_W

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  NUM_CH  per-channel run enable, active-high
load  input  1  one-cycle strobe: write div_val to channel ch_sel
ch_sel  input  $clog2(NUM_CH) (min 1)  target channel for load
div_val  input  CNT_W  requested half-period in clk cycles
clk_out  output  NUM_CH  divided square wave per channel
tick  output  NUM_CH  one-cycle pulse on every clk_out toggle
locked  output  NUM_CH  channel running at its active half-period
upd_pending  output  NUM_CH  a loaded value is waiting for terminal count
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Per-channel state: cnt[CNT_W], act_half[CNT_W], pend_half[CNT_W], pend_valid, q, lock.
- Reset (reset=0, asynchronous, no clock needed): cnt=0, act_half=DEFAULT_HALF, pend_valid=0, q=0, lock=0. All outputs are 0, including load_err.
- Running (en[i]=1): cnt increments each cycle. When cnt==act_half-1 (terminal count):
  - q toggles and cnt goes to 0.
  - tick[i]=1 for that cycle only (registered, aligned with the clk_out edge).
  - If pend_valid, then act_half<=pend_half, pend_valid<=0, lock<=0.
  - Otherwise lock<=1.
- Resulting timing: clk_out period = 2*act_half cycles at 50% duty. The first toggle occurs act_half cycles after en is first sampled high.
- The locked flag rises at the first terminal count after enable. After an update it rises at the first terminal count completed with the new value.
- Disabled (en[i]=0): cnt<=0, q holds its level, tick=0, lock<=0. On re-enable a full half-period elapses before the next toggle.
- Load accepted when load=1, ch_sel<NUM_CH and div_val!=0:
  - Channel enabled: pend_half<=div_val, pend_valid<=1.
  - Channel disabled: act_half<=div_val directly, and pend_valid stays 0.
- Load rejected when load=1 and (ch_sel>=NUM_CH or div_val==0): no state change; load_err=1 for the next cycle.
- Second load before apply: the last value wins; pend_valid stays 1.
- Load in the same cycle as a terminal count: the terminal count applies the old pending value (if any). The new value becomes pending, so pend_valid=1 afterwards.
- Half-period 1: the output toggles every cycle (clk_out=clk/2) and tick is high continuously.
- Counter never exceeds act_half-1. No wrap-around at 2**CNT_W is possible.
- upd_pending[i] = pend_valid[i].
- Channels are fully independent; only the load port is shared.

Decomposition:
- Package clkdiv_pkg holds:
  - default constants (DEFAULT_HALF, max NUM_CH);
  - a localparam function for the ch_sel width;
  - a channel-state struct typedef (cnt, act_half, pend_half, pend_valid, q, lock).
- Sub-module clkdiv_channel implements one channel: counter, shadow register, toggle and lock logic.
- The top level instantiates NUM_CH copies in a generate loop. It also decodes load/ch_sel into per-channel write strobes and generates load_err.

Test Plan:
(NUM_CH=4, CNT_W=8, DEFAULT_HALF=5 for all scenarios.)
1. Release reset, set en=4'b0001 -> clk_out[0] first rises 5 cycles later and then toggles every 5 cycles; tick[0] is high for 1 cycle at each toggle; locked[0]=1 from the first toggle; channels 1-3 stay 0.
2. ch0 running, load ch_sel=0 div_val=3 at cnt=2 -> upd_pending[0]=1; current half-period completes at 5 cycles with locked[0] dropping there; subsequent half-periods are 3 cycles; upd_pending clears at that toggle; locked[0] returns 3 cycles later.
3. Load ch_sel=1 div_val=0, then ch_sel=2 div_val=7 with en[2]=0 -> load_err pulses once (for the div_val=0 load); ch1 is unchanged; ch2 then enabled toggles every 7 cycles with no pending phase.
4. ch0 running, drop en[0] at cnt=2 -> clk_out[0] is frozen, locked[0]=0, tick silent; re-enable -> next toggle exactly 5 cycles later.
5. Assert reset=0 between clock edges with all channels running -> clk_out, tick, locked and upd_pending go to 0 immediately; after release, half-periods are back to 5.
6. Load div_val=4 in the exact cycle ch0 hits terminal count with pending value 3 -> that toggle applies 3 and upd_pending stays 1; the next toggle applies 4.
